// File: rtl/inert_pkg.sv
// Shared types and widths for the inertial attitude integrator.
package inert_pkg;

    typedef enum logic [1:0] {UNCAL, CAL, RUN} state_t;

    localparam int OUT_W  = 16;
    localparam int RATE_W = 16;

endpackage

// File: rtl/inertial_integrator_if.sv
// Sample/attitude bundle between the sensor front end and the integrator.
interface inertial_integrator_if;
    import inert_pkg::*;

    logic                     strt_cal;
    logic                     vld;
    logic signed [RATE_W-1:0] ptch_rt;
    logic signed [RATE_W-1:0] roll_rt;
    logic signed [RATE_W-1:0] yaw_rt;
    logic signed [RATE_W-1:0] ax;
    logic signed [RATE_W-1:0] ay;
    logic                     cal_done;
    logic signed [OUT_W-1:0]  ptch;
    logic signed [OUT_W-1:0]  roll;
    logic signed [OUT_W-1:0]  yaw;
    logic                     vld_out;

    modport master (
        output strt_cal, vld, ptch_rt, roll_rt, yaw_rt, ax, ay,
        input  cal_done, ptch, roll, yaw, vld_out
    );

    modport slave (
        input  strt_cal, vld, ptch_rt, roll_rt, yaw_rt, ax, ay,
        output cal_done, ptch, roll, yaw, vld_out
    );

endinterface

// File: rtl/axis_integrator.sv
// One attitude axis: offset-corrected rate integration with optional
// complementary accelerometer fusion and saturation to the integrator range.
module axis_integrator
    import inert_pkg::*;
#(
    parameter int INT_W    = 27,
    parameter int FUSION   = 1024,
    parameter int ACC_GAIN = 327,
    parameter bit FUSE_EN  = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     step,
    input  logic signed [RATE_W-1:0] rt,
    input  logic signed [RATE_W-1:0] off,
    input  logic signed [RATE_W-1:0] a,
    output logic signed [OUT_W-1:0]  out
);

    localparam int SUM_W = INT_W + 2;
    localparam logic signed [SUM_W-1:0] SAT_MAX  = {3'b000, {(INT_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN  = {3'b111, {(INT_W-1){1'b0}}};
    localparam logic signed [SUM_W-1:0] FUSE_MAG = SUM_W'(FUSION);
    localparam logic signed [9:0]       GAIN     = 10'(ACC_GAIN);

    logic signed [INT_W-1:0]  integ;
    logic signed [INT_W-1:0]  integ_nxt;
    logic signed [RATE_W:0]   diff;
    logic signed [25:0]       acc_prod;
    logic signed [OUT_W-1:0]  acc_ang;
    logic signed [SUM_W-1:0]  fuse;
    logic signed [SUM_W-1:0]  sum;

    assign out      = integ[INT_W-1 -: OUT_W];
    assign diff     = (RATE_W+1)'(rt) - (RATE_W+1)'(off);
    assign acc_prod = 26'(a) * 26'(GAIN);
    assign acc_ang  = acc_prod[25 -: OUT_W];

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        fuse      = '0;
        sum       = '0;
        integ_nxt = integ;
        if (FUSE_EN) begin
            if (acc_ang > out)      fuse = FUSE_MAG;
            else if (acc_ang < out) fuse = -FUSE_MAG;
        end
        // Two guard bits hold the sum of three signed terms without wrapping.
        sum = SUM_W'(integ) + SUM_W'(diff) + fuse;
        if (sum > SAT_MAX)      integ_nxt = SAT_MAX[INT_W-1:0];
        else if (sum < SAT_MIN) integ_nxt = SAT_MIN[INT_W-1:0];
        else                    integ_nxt = sum[INT_W-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) integ <= '0;
        else if (step)     integ <= integ_nxt;
    end

endmodule

// File: rtl/inertial_integrator.sv
// Gyro-offset calibration FSM plus three axis integrators producing
// pitch/roll/yaw attitude with a one-cycle update strobe.
module inertial_integrator
    import inert_pkg::*;
#(
    parameter int CAL_LOG2 = 11,
    parameter int INT_W    = 27,
    parameter int FUSION   = 1024,
    parameter int ACC_GAIN = 327
) (
    input  logic                 clk,
    input  logic                 rst_n,
    inertial_integrator_if.slave bus
);

    localparam int ACC_W = RATE_W + CAL_LOG2;

    state_t                    state, state_nxt;
    logic                      cal_clr, cal_add, cal_fin, int_clr, int_step;
    logic [CAL_LOG2-1:0]       cnt;
    logic signed [RATE_W-1:0]  rate    [3];
    logic signed [ACC_W-1:0]   acc     [3];
    logic signed [ACC_W-1:0]   acc_nxt [3];
    logic signed [RATE_W-1:0]  off     [3];

    assign rate[0] = bus.ptch_rt;
    assign rate[1] = bus.roll_rt;
    assign rate[2] = bus.yaw_rt;

    always_comb begin
        for (int i = 0; i < 3; i++) acc_nxt[i] = acc[i] + ACC_W'(rate[i]);
    end

    // strt_cal outranks vld in every state; the coincident sample is dropped.
    always_comb begin
        state_nxt = state;
        cal_clr   = 1'b0;
        cal_add   = 1'b0;
        cal_fin   = 1'b0;
        int_clr   = 1'b0;
        int_step  = 1'b0;
        case (state)
            UNCAL: begin
                if (bus.strt_cal) begin
                    state_nxt = CAL;
                    cal_clr   = 1'b1;
                    int_clr   = 1'b1;
                end
            end
            CAL: begin
                if (bus.strt_cal) begin
                    cal_clr = 1'b1;
                    int_clr = 1'b1;
                end else if (bus.vld) begin
                    cal_add = 1'b1;
                    if (&cnt) begin
                        cal_fin   = 1'b1;
                        int_clr   = 1'b1;
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (bus.strt_cal) begin
                    state_nxt = CAL;
                    cal_clr   = 1'b1;
                    int_clr   = 1'b1;
                end else if (bus.vld) begin
                    int_step = 1'b1;
                end
            end
            default: state_nxt = UNCAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= UNCAL;
        else        state <= state_nxt;
    end

    // NOTE: the small accumulator/offset arrays are plain registers and are cleared by reset like any flop.
    always_ff @(posedge clk) begin
        if (!rst_n || cal_clr) begin
            cnt <= '0;
            for (int i = 0; i < 3; i++) acc[i] <= '0;
        end else if (cal_add) begin
            cnt <= cnt + 1'b1;
            for (int i = 0; i < 3; i++) acc[i] <= acc_nxt[i];
        end
    end

    // Offset is the mean: the final sum shifted right by CAL_LOG2, kept to 16 bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) off[i] <= '0;
        end else if (cal_fin) begin
            for (int i = 0; i < 3; i++) off[i] <= acc_nxt[i][CAL_LOG2 +: RATE_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.cal_done <= 1'b0;
            bus.vld_out  <= 1'b0;
        end else begin
            bus.cal_done <= cal_fin;
            bus.vld_out  <= int_step;
        end
    end

    axis_integrator #(
        .INT_W(INT_W), .FUSION(FUSION), .ACC_GAIN(ACC_GAIN), .FUSE_EN(1'b1)
    ) u_ptch (
        .clk(clk), .rst_n(rst_n), .clr(int_clr), .step(int_step),
        .rt(bus.ptch_rt), .off(off[0]), .a(bus.ay), .out(bus.ptch)
    );

    axis_integrator #(
        .INT_W(INT_W), .FUSION(FUSION), .ACC_GAIN(ACC_GAIN), .FUSE_EN(1'b1)
    ) u_roll (
        .clk(clk), .rst_n(rst_n), .clr(int_clr), .step(int_step),
        .rt(bus.roll_rt), .off(off[1]), .a(bus.ax), .out(bus.roll)
    );

    axis_integrator #(
        .INT_W(INT_W), .FUSION(FUSION), .ACC_GAIN(ACC_GAIN), .FUSE_EN(1'b0)
    ) u_yaw (
        .clk(clk), .rst_n(rst_n), .clr(int_clr), .step(int_step),
        .rt(bus.yaw_rt), .off(off[2]), .a('0), .out(bus.yaw)
    );

endmodule

// File: tb/tb_inertial_integrator.sv
// Directed bench for inertial_integrator: arithmetic reference model checked
// every cycle, plus hand-computed literal expectations.
module tb_inertial_integrator;

    localparam int CAL_LOG2 = 2;
    localparam int INT_W    = 27;
    localparam int FUSION   = 1024;
    localparam int ACC_GAIN = 327;
    localparam int N_CAL    = 1 << CAL_LOG2;
    localparam longint INT_MAX = (longint'(1) << (INT_W-1)) - 1;
    localparam longint INT_MIN = -(longint'(1) << (INT_W-1));
    localparam int M_UNCAL = 0;
    localparam int M_CAL   = 1;
    localparam int M_RUN   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inertial_integrator_if bus();

    inertial_integrator #(
        .CAL_LOG2(CAL_LOG2), .INT_W(INT_W), .FUSION(FUSION), .ACC_GAIN(ACC_GAIN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    int     m_mode = M_UNCAL;
    longint m_sum [3];
    int     m_cnt;
    int     m_off [3];
    longint m_int [3];
    logic   m_vld_out  = 1'b0;
    logic   m_cal_done = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int s16(input longint v);
        logic signed [15:0] t;
        t = v[15:0];
        return int'(t);
    endfunction

    function automatic int out16(input longint v);
        return s16(v >>> (INT_W-16));
    endfunction

    // Reference behaviour for one clock edge, from the sampled inputs.
    task automatic model_edge();
        int rt [3];
        int a  [3];
        longint s;
        int fuse, ang, cur;
        rt[0] = int'(bus.ptch_rt); rt[1] = int'(bus.roll_rt); rt[2] = int'(bus.yaw_rt);
        a[0]  = int'(bus.ay);      a[1]  = int'(bus.ax);      a[2]  = 0;
        m_vld_out  = 1'b0;
        m_cal_done = 1'b0;
        if (!rst_n) begin
            m_mode = M_UNCAL;
            m_cnt  = 0;
            for (int i = 0; i < 3; i++) begin
                m_sum[i] = 0; m_off[i] = 0; m_int[i] = 0;
            end
        end else if (bus.strt_cal) begin
            m_mode = M_CAL;
            m_cnt  = 0;
            for (int i = 0; i < 3; i++) begin
                m_sum[i] = 0; m_int[i] = 0;
            end
        end else if (bus.vld && m_mode == M_CAL) begin
            for (int i = 0; i < 3; i++) m_sum[i] += rt[i];
            m_cnt++;
            if (m_cnt == N_CAL) begin
                for (int i = 0; i < 3; i++) begin
                    m_off[i] = s16(m_sum[i] >>> CAL_LOG2);
                    m_int[i] = 0;
                end
                m_mode     = M_RUN;
                m_cal_done = 1'b1;
            end
        end else if (bus.vld && m_mode == M_RUN) begin
            for (int i = 0; i < 3; i++) begin
                fuse = 0;
                if (i < 2) begin
                    ang = (a[i] * ACC_GAIN) >>> 10;
                    cur = out16(m_int[i]);
                    if (ang > cur)      fuse = FUSION;
                    else if (ang < cur) fuse = -FUSION;
                end
                s = m_int[i] + (rt[i] - m_off[i]) + fuse;
                if (s > INT_MAX) s = INT_MAX;
                if (s < INT_MIN) s = INT_MIN;
                m_int[i] = s;
            end
            m_vld_out = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("vld_out",  {15'b0, bus.vld_out},  {15'b0, m_vld_out});
            check("cal_done", {15'b0, bus.cal_done}, {15'b0, m_cal_done});
            check("ptch", bus.ptch, 16'(out16(m_int[0])));
            check("roll", bus.roll, 16'(out16(m_int[1])));
            check("yaw",  bus.yaw,  16'(out16(m_int[2])));
        end
    end

    task automatic tick(input bit s, input bit v);
        bus.strt_cal = s;
        bus.vld      = v;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        bus.strt_cal = 1'b0;
        bus.vld      = 1'b0;
    endtask

    task automatic set_rates(input logic [15:0] p, input logic [15:0] r, input logic [15:0] y,
                             input logic [15:0] x, input logic [15:0] yy);
        bus.ptch_rt = p; bus.roll_rt = r; bus.yaw_rt = y; bus.ax = x; bus.ay = yy;
    endtask

    logic [15:0] vec [6][5];

    initial begin
        vec = '{'{16'h0010, 16'hFFF0, 16'h0100, 16'h4000, 16'hC000},
                '{16'hF000, 16'h2000, 16'hFF00, 16'h8000, 16'h7FFF},
                '{16'h0000, 16'h0000, 16'h0005, 16'h0000, 16'h0000},
                '{16'h1234, 16'hEDCC, 16'h8000, 16'h0C35, 16'hF3CB},
                '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF},
                '{16'h0010, 16'hFFF0, 16'h0000, 16'h0000, 16'h0000}};
        bus.strt_cal = 1'b0;
        bus.vld      = 1'b0;
        set_rates(16'h0, 16'h0, 16'h0, 16'h0, 16'h0);

        rst_n = 1'b0;
        tick(0, 0);
        tick(0, 0);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        check("reset_ptch", bus.ptch, 16'h0000);
        check("reset_vld_out", {15'b0, bus.vld_out}, 16'h0000);
        check("reset_cal_done", {15'b0, bus.cal_done}, 16'h0000);

        // vld before any calibration is ignored
        set_rates(16'h1234, 16'h8001, 16'h7FFF, 16'h4000, 16'hC000);
        repeat (5) tick(0, 1);
        check("uncal_yaw", bus.yaw, 16'h0000);
        check("uncal_ptch", bus.ptch, 16'h0000);

        // calibration: offsets 0x0010, 0xFFF0, 0
        tick(1, 0);
        set_rates(16'h0010, 16'hFFF0, 16'h0000, 16'h0000, 16'h0000);
        for (int i = 0; i < N_CAL; i++) begin
            tick(0, 1);
            if (i < N_CAL-1) check("cal_done_early", {15'b0, bus.cal_done}, 16'h0000);
        end
        check("cal_done_pulse", {15'b0, bus.cal_done}, 16'h0001);
        tick(0, 0);
        check("cal_done_drop", {15'b0, bus.cal_done}, 16'h0000);

        // diff = 0x0800 -> int 2048 then 2048+2048-1024 = 3072
        set_rates(16'h0810, 16'hFFF0, 16'h0000, 16'h0000, 16'h0000);
        tick(0, 1);
        check("run1_vld_out", {15'b0, bus.vld_out}, 16'h0001);
        check("run1_ptch", bus.ptch, 16'h0001);
        check("run1_roll", bus.roll, 16'h0000);
        tick(0, 1);
        check("run2_ptch", bus.ptch, 16'h0001);
        check("run2_yaw", bus.yaw, 16'h0000);
        tick(0, 0);
        check("hold_vld_out", {15'b0, bus.vld_out}, 16'h0000);
        check("hold_ptch", bus.ptch, 16'h0001);

        // mixed rate/accel patterns, back-to-back and with gaps
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 6; i++) begin
                set_rates(vec[i][0], vec[i][1], vec[i][2], vec[i][3], vec[i][4]);
                tick(0, 1);
                if (k == 1) tick(0, 0);
            end
        end

        // strt_cal beats a coincident vld in RUN
        tick(1, 1);
        check("restart_vld_out", {15'b0, bus.vld_out}, 16'h0000);
        check("restart_ptch", bus.ptch, 16'h0000);
        check("restart_roll", bus.roll, 16'h0000);
        check("restart_yaw", bus.yaw, 16'h0000);
        set_rates(16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        repeat (N_CAL) tick(0, 1);
        check("recal_done", {15'b0, bus.cal_done}, 16'h0001);

        // positive / negative saturation
        set_rates(16'h7FFF, 16'h8000, 16'h7FFF, 16'h0000, 16'h0000);
        repeat (2200) tick(0, 1);
        check("sat_yaw_max", bus.yaw, 16'h7FFF);
        check("sat_ptch_max", bus.ptch, 16'h7FFF);
        check("sat_roll_min", bus.roll, 16'h8000);
        repeat (3) tick(0, 1);
        check("sat_yaw_hold", bus.yaw, 16'h7FFF);

        tick(1, 0);
        set_rates(16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        repeat (N_CAL) tick(0, 1);
        set_rates(16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'h0000);
        repeat (2100) tick(0, 1);
        check("sat_yaw_min", bus.yaw, 16'h8000);

        // reset in the middle of calibration
        tick(1, 0);
        set_rates(16'h0020, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000);
        repeat (2) tick(0, 1);
        rst_n = 1'b0;
        tick(0, 0);
        rst_n = 1'b1;
        check("midrst_cal_done", {15'b0, bus.cal_done}, 16'h0000);
        check("midrst_yaw", bus.yaw, 16'h0000);
        repeat (2) tick(0, 1);
        check("midrst_no_done", {15'b0, bus.cal_done}, 16'h0000);
        tick(1, 0);
        repeat (N_CAL) tick(0, 1);
        check("midrst_recal_done", {15'b0, bus.cal_done}, 16'h0001);
        set_rates(16'h0820, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000);
        tick(0, 1);
        check("midrst_ptch", bus.ptch, 16'h0001);
        check("midrst_yaw_off", bus.yaw, 16'h0000);

        tick(0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
